// File: rtl/mmcm_drp_reconfig_if.sv
// mmcm_drp_reconfig_if
// DRP bus between the reconfiguration initiator and the MMCME4 DRP port.
//   daddr  : 7-bit register address
//   den    : one-cycle access strobe
//   dwe    : write enable, meaningful only while den is high
//   di     : write data
//   drp_do : read data, valid while drdy is high
//   drdy   : access complete
// master = the initiator, slave = the MMCM (or a model of it).
interface mmcm_drp_reconfig_if;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] drp_do;
  logic        drdy;

  modport master (output daddr, output den, output dwe, output di,
                  input drp_do, input drdy);
  modport slave  (input daddr, input den, input dwe, input di,
                  output drp_do, output drdy);
endinterface

// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig
// Reprograms the CLKFBOUT multiplier and CLKOUT0 divider of the MMCME4 at
// run time: holds the MMCM in reset, read-modify-writes four DRP registers,
// releases reset and waits for LOCKED.
// Ports:
//   clk, reset          : control clock (also MMCM DCLK), async active-high reset
//   start, mult, div0   : request with the new multiplier / divider (1..126)
//   busy, done          : sequence in progress / one-cycle success pulse
//   error, err_code     : sticky failure flag, 1=illegal 2=drdy timeout 3=lock timeout
//   mmcm_rst            : MMCM RST
//   mmcm_locked         : MMCM LOCKED, asynchronous to clk
//   drp                 : DRP master port
module mmcm_drp_reconfig #(
  parameter int RST_HOLD     = 16,
  parameter int DRDY_TIMEOUT = 1023,
  parameter int LOCK_TIMEOUT = 1048575
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [6:0]                 mult,
  input  logic [6:0]                 div0,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 err_code,
  output logic                       mmcm_rst,
  input  logic                       mmcm_locked,
  mmcm_drp_reconfig_if.master        drp
);

  // One shared counter serves the reset hold, drdy and lock timeouts.
  localparam int CNT_MAX_A = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, HOLD, RD, WAIT_RD, WR, WAIT_WR, RELEASE, WAIT_LOCK, FAIL
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       step;
  logic [6:0]       mult_q, div_q;
  logic [15:0]      rd_data;
  logic             lock_meta, lock_sync;

  logic             accept, illegal, cnt_clr, cnt_inc, step_inc;
  logic             capture, rst_clr, lock_ok;
  logic [1:0]       fail_code;

  logic [6:0]       cur_val, half, rest;
  logic [5:0]       enc_high, enc_low;
  logic             enc_edge, enc_nc;
  logic [6:0]       step_addr;
  logic [15:0]      wr_data;

  assign busy = (state != IDLE) && (state != FAIL);

  // Two-flop synchronizer for the asynchronous LOCKED input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= mmcm_locked;
      lock_sync <= lock_meta;
    end
  end

  // Divide encoding for the value selected by the current step. Steps 0/1
  // target CLKOUT0 (div0), steps 2/3 target CLKFBOUT (mult). A value of 1
  // uses no_count with high=low=1.
  always_comb begin
    cur_val  = step[1] ? mult_q : div_q;
    half     = cur_val >> 1;
    rest     = cur_val - half;
    enc_edge = cur_val[0];
    enc_nc   = (cur_val == 7'd1);
    enc_high = half[5:0];
    enc_low  = rest[5:0];
    if (enc_nc) begin
      enc_high = 6'd1;
      enc_low  = 6'd1;
    end
    case (step)
      2'd0:    step_addr = 7'h08;
      2'd1:    step_addr = 7'h09;
      2'd2:    step_addr = 7'h14;
      default: step_addr = 7'h15;
    endcase
    // Odd steps are Reg2 (edge/no_count), even steps are Reg1 (high/low).
    if (step[0]) wr_data = {rd_data[15:8], enc_edge, enc_nc, rd_data[5:0]};
    else         wr_data = {rd_data[15:12], enc_high, enc_low};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state, DRP strobes and datapath controls. The DRP strobes are
  // decoded from the state so an asynchronous reset drops them at once.
  // RD/WR are always entered the cycle after drdy, so den never coincides
  // with drdy; drdy outside the wait states is simply not looked at.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    illegal    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    step_inc   = 1'b0;
    capture    = 1'b0;
    rst_clr    = 1'b0;
    lock_ok    = 1'b0;
    fail_code  = 2'd0;
    drp.den    = 1'b0;
    drp.dwe    = 1'b0;
    drp.daddr  = 7'd0;
    drp.di     = 16'd0;
    case (state)
      IDLE: begin
        // done is high in the first idle cycle; a start then is dropped.
        if (start && !done) begin
          if (mult == 7'd0 || mult == 7'd127 || div0 == 7'd0 || div0 == 7'd127) begin
            illegal = 1'b1;
          end else begin
            accept     = 1'b1;
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_clr    = 1'b1;
          next_state = RD;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RD: begin
        drp.den    = 1'b1;
        drp.daddr  = step_addr;
        cnt_clr    = 1'b1;
        next_state = WAIT_RD;
      end
      WAIT_RD: begin
        if (drp.drdy) begin
          capture    = 1'b1;
          next_state = WR;
        end else if (cnt == DRDY_LAST) begin
          fail_code  = 2'd2;
          next_state = FAIL;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WR: begin
        drp.den    = 1'b1;
        drp.dwe    = 1'b1;
        drp.daddr  = step_addr;
        drp.di     = wr_data;
        cnt_clr    = 1'b1;
        next_state = WAIT_WR;
      end
      WAIT_WR: begin
        if (drp.drdy) begin
          step_inc   = 1'b1;
          next_state = (step == 2'd3) ? RELEASE : RD;
        end else if (cnt == DRDY_LAST) begin
          fail_code  = 2'd2;
          next_state = FAIL;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RELEASE: begin
        rst_clr    = 1'b1;
        cnt_clr    = 1'b1;
        next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_sync) begin
          lock_ok    = 1'b1;
          next_state = IDLE;
        end else if (cnt == LOCK_LAST) begin
          fail_code  = 2'd3;
          next_state = FAIL;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FAIL: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers: request latch, counters, read capture and the
  // registered status outputs. error/err_code are set on entry to FAIL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      step     <= 2'd0;
      mult_q   <= 7'd0;
      div_q    <= 7'd0;
      rd_data  <= 16'd0;
      mmcm_rst <= 1'b0;
      error    <= 1'b0;
      err_code <= 2'd0;
      done     <= 1'b0;
    end else begin
      done <= lock_ok;
      if (accept || cnt_clr) cnt <= '0;
      else if (cnt_inc)      cnt <= cnt + 1'b1;
      if (accept)        step <= 2'd0;
      else if (step_inc) step <= step + 2'd1;
      if (capture) rd_data <= drp.drp_do;
      if (accept) begin
        mult_q   <= mult;
        div_q    <= div0;
        mmcm_rst <= 1'b1;
        error    <= 1'b0;
        err_code <= 2'd0;
      end
      if (illegal) begin
        error    <= 1'b1;
        err_code <= 2'd1;
      end
      if (rst_clr) mmcm_rst <= 1'b0;
      if (fail_code != 2'd0) begin
        error    <= 1'b1;
        err_code <= fail_code;
        mmcm_rst <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// tb_mmcm_drp_reconfig
// Directed bench for mmcm_drp_reconfig with a behavioural DRP slave and a
// LOCKED model. LOCK_TIMEOUT is shortened to 200 so the lock timeout is
// reachable in a short run.
module tb_mmcm_drp_reconfig;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  mult;
  logic [6:0]  div0;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic        mmcm_rst;
  logic        mmcm_locked;

  mmcm_drp_reconfig_if drp_bus ();

  mmcm_drp_reconfig #(
    .RST_HOLD     (16),
    .DRDY_TIMEOUT (1023),
    .LOCK_TIMEOUT (200)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mult        (mult),
    .div0        (div0),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .mmcm_rst    (mmcm_rst),
    .mmcm_locked (mmcm_locked),
    .drp         (drp_bus.slave)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          wr_n, rd_n, den_n, done_cnt;
  logic [6:0]  wr_addr [8];
  logic [15:0] wr_data [8];
  bit          rst_ok;
  int          drop_read;
  int          resp_mode;
  bit          lock_en;
  int          lock_delay;

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Overall time limit so a stuck DUT cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count done pulses on the falling edge, clear of the active edge.
  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  function automatic logic [15:0] respValue(input logic [6:0] addr);
    if (resp_mode == 1) return 16'hFFFF;
    if (addr == 7'h08 || addr == 7'h14) return 16'h1000;
    return 16'h0000;
  endfunction

  // DRP slave model: records every access, answers two cycles after den,
  // and can withhold the answer to one chosen read (1-based).
  initial begin
    int         countdown;
    logic [6:0] last_addr;
    countdown      = 0;
    last_addr      = 7'd0;
    drp_bus.drdy   = 1'b0;
    drp_bus.drp_do = 16'd0;
    forever begin
      @(posedge clk);
      #1;
      drp_bus.drdy = 1'b0;
      if (reset) begin
        countdown = 0;
      end else begin
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            drp_bus.drdy   = 1'b1;
            drp_bus.drp_do = respValue(last_addr);
          end
        end
        if (drp_bus.den === 1'b1) begin
          den_n++;
          if (mmcm_rst !== 1'b1) rst_ok = 1'b0;
          last_addr = drp_bus.daddr;
          if (drp_bus.dwe === 1'b1) begin
            if (wr_n < 8) begin
              wr_addr[wr_n] = drp_bus.daddr;
              wr_data[wr_n] = drp_bus.di;
            end
            wr_n++;
            countdown = 2;
          end else begin
            rd_n++;
            if (rd_n != drop_read) countdown = 2;
          end
        end
      end
    end
  end

  // LOCKED model: low while mmcm_rst is high, rises lock_delay cycles
  // after mmcm_rst falls when enabled.
  initial begin
    int since;
    bit armed;
    since       = 0;
    armed       = 1'b0;
    mmcm_locked = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mmcm_rst === 1'b1) begin
        mmcm_locked = 1'b0;
        armed       = 1'b1;
        since       = 0;
      end else if (armed) begin
        since++;
        if (lock_en && since >= lock_delay) begin
          mmcm_locked = 1'b1;
          armed       = 1'b0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] m, input logic [6:0] d);
    mult  = m;
    div0  = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clearLog;
    wr_n  = 0;
    rd_n  = 0;
    den_n = 0;
  endtask

  task automatic waitIdle(input int maxCycles, input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput({tag, "_reached_idle"}, busy, 0);
  endtask

  initial begin
    int n;
    int c;
    int done_before;
    reset      = 1'b1;
    start      = 1'b0;
    mult       = 7'd0;
    div0       = 7'd0;
    drop_read  = 0;
    resp_mode  = 0;
    lock_en    = 1'b1;
    lock_delay = 100;
    rst_ok     = 1'b1;
    clearLog();

    // Reset state
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_den", drp_bus.den, 0);
    checkOutput("rst_dwe", drp_bus.dwe, 0);
    checkOutput("rst_daddr", drp_bus.daddr, 0);
    checkOutput("rst_di", drp_bus.di, 0);
    checkOutput("rst_mmcm_rst", mmcm_rst, 0);
    reset = 1'b0;
    tick();

    // Nominal reconfiguration: mult=12, div0=15
    $display("[TB] nominal sequence mult=12 div0=15");
    done_before = done_cnt;
    applyStimulus(7'd12, 7'd15);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_mmcm_rst", mmcm_rst, 1);
    waitIdle(2000, "t1");
    tick();
    checkOutput("t1_writes", wr_n, 4);
    checkOutput("t1_reads", rd_n, 4);
    checkOutput("t1_addr0", wr_addr[0], 7'h08);
    checkOutput("t1_data0", wr_data[0], 16'h11C8);
    checkOutput("t1_addr1", wr_addr[1], 7'h09);
    checkOutput("t1_data1", wr_data[1], 16'h0080);
    checkOutput("t1_addr2", wr_addr[2], 7'h14);
    checkOutput("t1_data2", wr_data[2], 16'h1186);
    checkOutput("t1_addr3", wr_addr[3], 7'h15);
    checkOutput("t1_data3", wr_data[3], 16'h0000);
    checkOutput("t1_rst_during_drp", rst_ok, 1);
    checkOutput("t1_done_pulses", done_cnt - done_before, 1);
    checkOutput("t1_error", error, 0);
    checkOutput("t1_mmcm_rst_released", mmcm_rst, 0);

    // Divide-by-1 and all-ones read data
    $display("[TB] div0=1 mult=2 with all-ones reads");
    clearLog();
    resp_mode   = 1;
    done_before = done_cnt;
    applyStimulus(7'd2, 7'd1);
    waitIdle(2000, "t2");
    tick();
    checkOutput("t2_writes", wr_n, 4);
    checkOutput("t2_data0", wr_data[0], 16'hF041);
    checkOutput("t2_data1", wr_data[1], 16'hFFFF);
    checkOutput("t2_data2", wr_data[2], 16'hF041);
    checkOutput("t2_data3", wr_data[3], 16'hFF3F);
    checkOutput("t2_done_pulses", done_cnt - done_before, 1);
    resp_mode = 0;

    // Illegal values, then a legal boundary request clears the error
    $display("[TB] illegal request handling");
    clearLog();
    applyStimulus(7'd0, 7'd5);
    checkOutput("t3_busy_mult0", busy, 0);
    checkOutput("t3_error_mult0", error, 1);
    checkOutput("t3_code_mult0", err_code, 1);
    repeat (5) tick();
    applyStimulus(7'd10, 7'd127);
    checkOutput("t3_busy_div127", busy, 0);
    checkOutput("t3_code_div127", err_code, 1);
    repeat (5) tick();
    checkOutput("t3_no_den", den_n, 0);
    done_before = done_cnt;
    applyStimulus(7'd126, 7'd126);
    checkOutput("t3_busy_valid", busy, 1);
    checkOutput("t3_error_cleared", error, 0);
    checkOutput("t3_code_cleared", err_code, 0);
    waitIdle(2000, "t3");
    tick();
    checkOutput("t3_data0_126", wr_data[0], 16'h1FFF);
    checkOutput("t3_data2_126", wr_data[2], 16'h1FFF);
    checkOutput("t3_data3_126", wr_data[3], 16'h0000);
    checkOutput("t3_done_pulses", done_cnt - done_before, 1);

    // drdy withheld on the second read
    $display("[TB] drdy timeout on second read");
    clearLog();
    drop_read = 2;
    applyStimulus(7'd4, 7'd4);
    n = 0;
    while (rd_n < 2 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("t4_second_read_issued", rd_n, 2);
    c = 0;
    while (error !== 1'b1 && c < 1100) begin
      tick();
      c++;
    end
    checkOutput("t4_timeout_window", (c >= 1023 && c <= 1026), 1);
    checkOutput("t4_err_code", err_code, 2);
    checkOutput("t4_mmcm_rst", mmcm_rst, 0);
    checkOutput("t4_busy", busy, 0);
    drop_read = 0;
    repeat (3) tick();

    // Lock never arrives; a second start while busy is ignored
    $display("[TB] lock timeout");
    clearLog();
    lock_en = 1'b0;
    applyStimulus(7'd5, 7'd5);
    checkOutput("t5_busy", busy, 1);
    checkOutput("t5_error_cleared", error, 0);
    applyStimulus(7'd7, 7'd7);
    n = 0;
    while (mmcm_rst === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checkOutput("t5_released", mmcm_rst, 0);
    c = 0;
    while (error !== 1'b1 && c < 300) begin
      tick();
      c++;
    end
    checkOutput("t5_timeout_window", (c >= 199 && c <= 202), 1);
    checkOutput("t5_err_code", err_code, 3);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_writes", wr_n, 4);
    checkOutput("t5_kept_first_mult", wr_data[2], 16'h1083);
    repeat (3) tick();

    // Asynchronous reset while waiting for a write acknowledge
    $display("[TB] reset during write wait");
    clearLog();
    lock_en    = 1'b1;
    lock_delay = 100;
    applyStimulus(7'd12, 7'd15);
    n = 0;
    while (wr_n < 1 && n < 200) begin
      tick();
      n++;
    end
    tick();
    checkOutput("t6_mid_busy", busy, 1);
    checkOutput("t6_mid_mmcm_rst", mmcm_rst, 1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_mmcm_rst", mmcm_rst, 0);
    checkOutput("t6_async_den", drp_bus.den, 0);
    checkOutput("t6_async_dwe", drp_bus.dwe, 0);
    checkOutput("t6_async_busy", busy, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    clearLog();
    done_before = done_cnt;
    applyStimulus(7'd12, 7'd15);
    waitIdle(2000, "t6");
    tick();
    checkOutput("t6_writes", wr_n, 4);
    checkOutput("t6_addr0", wr_addr[0], 7'h08);
    checkOutput("t6_data0", wr_data[0], 16'h11C8);
    checkOutput("t6_data3", wr_data[3], 16'h0000);
    checkOutput("t6_done_pulses", done_cnt - done_before, 1);
    checkOutput("t6_error", error, 0);
    checkOutput("all_den_under_rst", rst_ok, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
